// File: rtl/crypto_csr_regs.sv
// AXI-Lite control/status register block for a block-cipher engine: stages key,
// input data and length, qualifies start requests, and captures results.
module crypto_csr_regs (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_axil_awaddr,
  input  logic         s_axil_awvalid,
  output logic         s_axil_awready,
  input  logic [31:0]  s_axil_wdata,
  input  logic         s_axil_wvalid,
  output logic         s_axil_wready,
  output logic [1:0]   s_axil_bresp,
  output logic         s_axil_bvalid,
  input  logic         s_axil_bready,
  input  logic [7:0]   s_axil_araddr,
  input  logic         s_axil_arvalid,
  output logic         s_axil_arready,
  output logic [31:0]  s_axil_rdata,
  output logic [1:0]   s_axil_rresp,
  output logic         s_axil_rvalid,
  input  logic         s_axil_rready,
  output logic         start,
  output logic         algo_sel,
  output logic [31:0]  i_total_len,
  output logic [127:0] key,
  output logic [127:0] din,
  input  logic         busy,
  input  logic         done,
  input  logic [127:0] dout
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_LEN     = 8'h08;
  localparam logic [7:0] ADDR_ERR_CNT = 8'h44;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  typedef enum logic {R_IDLE, R_VALID} r_state_t;

  // Write channel state
  logic        ready_en;
  logic        aw_held, w_held;
  logic [7:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  // Read channel state
  r_state_t    r_state, r_next;
  logic [31:0] rdata_q, rd_data;
  logic [1:0]  rresp_q, rd_resp;

  // Register file
  logic        start_q;
  logic        algo_sel_q;
  logic [31:0] len_q;
  logic [31:0] key_q  [4];
  logic [31:0] din_q  [4];
  logic [31:0] dout_q [4];
  logic        done_q;
  logic [31:0] err_cnt;

  function automatic logic is_rw_addr(input logic [7:0] a);
    case (a)
      ADDR_CTRL, ADDR_LEN,
      8'h10, 8'h14, 8'h18, 8'h1C,
      8'h20, 8'h24, 8'h28, 8'h2C: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  logic aw_hs, w_hs, b_hs, ar_hs;
  logic wr_commit, wr_ok, ctrl_wr;
  logic start_req, start_reject, start_accept, err_clr;

  assign s_axil_awready = ready_en & ~aw_held & ~bvalid_q;
  assign s_axil_wready  = ready_en & ~w_held & ~bvalid_q;
  assign s_axil_arready = ready_en & (r_state == R_IDLE);

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign b_hs  = bvalid_q & s_axil_bready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // Held address/data are consumed on the commit edge; bvalid keeps the ports closed.
  assign wr_commit = aw_held & w_held;
  assign wr_ok     = wr_commit & is_rw_addr(aw_addr_q);
  assign ctrl_wr   = wr_ok && (aw_addr_q == ADDR_CTRL);

  assign start_req    = ctrl_wr & w_data_q[0];
  assign err_clr      = ctrl_wr & w_data_q[2];
  assign start_reject = start_req & ((len_q == 32'd0) | (len_q[3:0] != 4'd0) | busy);
  assign start_accept = start_req & ~start_reject;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil_wdata;
      end
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= is_rw_addr(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // NOTE: the word arrays are real flops, not RAM, so they are cleared by reset like any register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      algo_sel_q <= 1'b0;
      len_q      <= '0;
      done_q     <= 1'b0;
      err_cnt    <= '0;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      start_q <= start_accept;
      if (wr_ok) begin
        case (aw_addr_q)
          ADDR_CTRL:                  algo_sel_q <= w_data_q[1];
          ADDR_LEN:                   len_q      <= w_data_q;
          8'h10, 8'h14, 8'h18, 8'h1C: key_q[aw_addr_q[3:2]] <= w_data_q;
          8'h20, 8'h24, 8'h28, 8'h2C: din_q[aw_addr_q[3:2]] <= w_data_q;
          default: ;
        endcase
      end
      // A completion arriving alongside an accepted start leaves DONE set.
      if (done) begin
        done_q    <= 1'b1;
        dout_q[0] <= dout[127:96];
        dout_q[1] <= dout[95:64];
        dout_q[2] <= dout[63:32];
        dout_q[3] <= dout[31:0];
      end else if (start_accept) begin
        done_q <= 1'b0;
      end
      if (err_clr)
        err_cnt <= '0;
      else if (start_reject && (err_cnt != 32'hFFFF_FFFF))
        err_cnt <= err_cnt + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axil_araddr)
      ADDR_CTRL:                  rd_data = {30'd0, algo_sel_q, 1'b0};
      ADDR_STATUS:                rd_data = {30'd0, done_q, busy};
      ADDR_LEN:                   rd_data = len_q;
      8'h10, 8'h14, 8'h18, 8'h1C: rd_data = key_q[s_axil_araddr[3:2]];
      8'h20, 8'h24, 8'h28, 8'h2C: rd_data = din_q[s_axil_araddr[3:2]];
      8'h30, 8'h34, 8'h38, 8'h3C: rd_data = dout_q[s_axil_araddr[3:2]];
      ADDR_ERR_CNT:               rd_data = err_cnt;
      default:                    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_VALID;
      R_VALID: if (s_axil_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read data is registered at address capture, so same-edge updates show the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = (r_state == R_VALID);
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;

  assign start       = start_q;
  assign algo_sel    = algo_sel_q;
  assign i_total_len = len_q;
  assign key         = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign din         = {din_q[0], din_q[1], din_q[2], din_q[3]};

endmodule

// File: tb/tb_crypto_csr_regs.sv
// Directed bench for crypto_csr_regs: AXI-Lite transactions with queued expected
// responses, engine handshake stimulus, and reset-abort scenarios.
module tb_crypto_csr_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_axil_awaddr;
  logic         s_axil_awvalid;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata;
  logic         s_axil_wvalid;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready;
  logic [7:0]   s_axil_araddr;
  logic         s_axil_arvalid;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready;
  logic         start;
  logic         algo_sel;
  logic [31:0]  i_total_len;
  logic [127:0] key;
  logic [127:0] din;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  always #5 clk = ~clk;

  crypto_csr_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .start(start), .algo_sel(algo_sel), .i_total_len(i_total_len), .key(key), .din(din),
    .busy(busy), .done(done), .dout(dout)
  );

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  // start is a full-cycle pulse, so counting at the falling edge sees it once.
  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns the start level seen in the bvalid cycle.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [1:0] exp_resp, output bit start_at_b);
    int n;
    bit aw_hs, w_hs;
    logic [1:0] e;
    bq.push_back(exp_resp);
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    s_axil_wdata  = d; s_axil_wvalid  = 1'b1;
    s_axil_bready = 1'b1;
    n = 0;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(negedge clk); n++;
      if (aw_hs) s_axil_awvalid = 1'b0;
      if (w_hs)  s_axil_wvalid  = 1'b0;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    while (!s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
    start_at_b = start;
    e = bq.pop_front();
    check($sformatf("bresp@%02h", a), {s_axil_bvalid, s_axil_bresp}, {1'b1, e});
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n;
    logic [33:0] e;
    rq.push_back({exp_r, exp_d});
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    n = 0;
    while (!s_axil_arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
    e = rq.pop_front();
    check($sformatf("read@%02h", a), {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, e});
    @(negedge clk);
  endtask

  bit   sb;
  bit   w_hs, aw_hs, stable;
  int   starts_before;
  logic [1:0] e2;

  initial begin
    rst_n = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    busy = 1'b0; done = 1'b0; dout = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, start,
           s_axil_bresp, s_axil_rresp, s_axil_rdata}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // Key load and a qualified start
    axi_write(8'h10, 32'h2b7e1516, OKAY, sb);
    axi_write(8'h14, 32'h28aed2a6, OKAY, sb);
    axi_write(8'h18, 32'habf71588, OKAY, sb);
    axi_write(8'h1C, 32'h09cf4f3c, OKAY, sb);
    check("key_out", key, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    axi_write(8'h08, 32'd64, OKAY, sb);
    check("len_out", i_total_len, 32'd64);
    starts_before = start_cnt;
    axi_write(8'h00, 32'h1, OKAY, sb);
    check("start_with_b", sb, 1'b1);
    check("start_single", start_cnt - starts_before, 1);
    axi_read(8'h44, 32'd0, OKAY);
    axi_read(8'h08, 32'd64, OKAY);

    // Length qualification and error counter clearing
    axi_write(8'h08, 32'd63, OKAY, sb);
    axi_write(8'h00, 32'h1, OKAY, sb);
    check("no_start_len63", sb, 1'b0);
    axi_read(8'h44, 32'd1, OKAY);
    axi_write(8'h08, 32'd17, OKAY, sb);
    axi_write(8'h00, 32'h1, OKAY, sb);
    axi_read(8'h44, 32'd2, OKAY);
    axi_write(8'h00, 32'h4, OKAY, sb);
    axi_read(8'h44, 32'd0, OKAY);
    axi_write(8'h08, 32'd0, OKAY, sb);
    axi_write(8'h00, 32'h1, OKAY, sb);
    axi_read(8'h44, 32'd1, OKAY);
    axi_write(8'h00, 32'h5, OKAY, sb);
    check("no_start_len0", sb, 1'b0);
    axi_read(8'h44, 32'd0, OKAY);

    // Busy rejection and saturation
    axi_write(8'h08, 32'd64, OKAY, sb);
    busy = 1'b1;
    axi_write(8'h00, 32'h1, OKAY, sb);
    check("no_start_busy", sb, 1'b0);
    axi_read(8'h44, 32'd1, OKAY);
    axi_read(8'h04, 32'h1, OKAY);
    force dut.err_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.err_cnt;
    @(negedge clk);
    axi_read(8'h44, 32'hFFFF_FFFF, OKAY);
    axi_write(8'h00, 32'h1, OKAY, sb);
    axi_read(8'h44, 32'hFFFF_FFFF, OKAY);
    axi_write(8'h00, 32'h4, OKAY, sb);
    axi_read(8'h44, 32'd0, OKAY);
    busy = 1'b0;

    // Result capture and DONE handling
    done = 1'b1; dout = 128'h7649abac_8119b246_cee98e9b_12e9197d;
    @(negedge clk);
    done = 1'b0; dout = '0;
    @(negedge clk);
    axi_read(8'h30, 32'h7649abac, OKAY);
    axi_read(8'h34, 32'h8119b246, OKAY);
    axi_read(8'h3C, 32'h12e9197d, OKAY);
    axi_read(8'h04, 32'h2, OKAY);
    axi_write(8'h30, 32'h1234_5678, SLVERR, sb);
    axi_read(8'h30, 32'h7649abac, OKAY);
    axi_write(8'h00, 32'h2, OKAY, sb);
    check("algo_sel_set", algo_sel, 1'b1);
    check("no_start_algo_only", sb, 1'b0);
    axi_read(8'h04, 32'h2, OKAY);
    axi_write(8'h00, 32'h3, OKAY, sb);
    check("start_clears_done", sb, 1'b1);
    axi_read(8'h04, 32'h0, OKAY);
    axi_read(8'h00, 32'h2, OKAY);
    busy = 1'b1;
    axi_write(8'h00, 32'h3, OKAY, sb);
    busy = 1'b0;

    // Data before address, delayed response acceptance
    bq.push_back(OKAY);
    s_axil_bready = 1'b0;
    s_axil_wdata = 32'hdeadbeef; s_axil_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_hs = s_axil_wvalid && s_axil_wready;
      @(negedge clk);
      if (w_hs) s_axil_wvalid = 1'b0;
    end
    check("w_held_closes_wready", {s_axil_wvalid, s_axil_wready, s_axil_awready, s_axil_bvalid}, 4'b0010);
    s_axil_awaddr = 8'h2C; s_axil_awvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0;
    for (int i = 0; i < 20 && !s_axil_bvalid; i++) @(negedge clk);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stable &= s_axil_bvalid & ~s_axil_awready & ~s_axil_wready & (s_axil_bresp == OKAY);
      @(negedge clk);
    end
    check("bvalid_held", stable, 1'b1);
    check("din_visible", din[31:0], 32'hdeadbeef);
    s_axil_bready = 1'b1;
    e2 = bq.pop_front();
    check("bresp_delayed", {s_axil_bvalid, s_axil_bresp}, {1'b1, e2});
    @(negedge clk);
    check("b_released", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
    axi_read(8'h2C, 32'hdeadbeef, OKAY);
    axi_write(8'h44, 32'd0, SLVERR, sb);
    axi_read(8'h44, 32'd1, OKAY);
    axi_write(8'h04, 32'h3, SLVERR, sb);
    axi_read(8'h50, 32'd0, SLVERR);

    // Reset with write response and read data both pending
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    s_axil_awaddr = 8'h08; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h100; s_axil_wvalid = 1'b1;
    s_axil_araddr = 8'h08; s_axil_arvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    @(negedge clk);
    check("both_pending", {s_axil_bvalid, s_axil_rvalid, s_axil_rdata}, {2'b11, 32'd64});
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_drops_pending",
          {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, start,
           s_axil_bresp, s_axil_rresp, s_axil_rdata}, '0);
    check("reset_clears_regs", {algo_sel, i_total_len, key, din}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset2", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    axi_read(8'h04, 32'h0, OKAY);
    axi_read(8'h30, 32'h0, OKAY);
    axi_read(8'h44, 32'h0, OKAY);

    // Reset between handshake and commit of a qualified start
    axi_write(8'h08, 32'd64, OKAY, sb);
    starts_before = start_cnt;
    s_axil_awaddr = 8'h00; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h1; s_axil_wvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_start", start_cnt - starts_before, 0);
    check("abort_no_b", {s_axil_bvalid, i_total_len}, '0);
    check("start_total", start_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crypto_csr_regs.md
CRYPTO_CSR_REGS -- requirements
Module: crypto_csr_regs

Interface
REQ-001 SHALL use ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL use ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL provide AXI-Lite write address: s_axil_awaddr in 8, s_axil_awvalid in 1, s_axil_awready out 1.
REQ-004 SHALL provide AXI-Lite write data: s_axil_wdata in 32, s_axil_wvalid in 1, s_axil_wready out 1 (no strobes, full-word writes only).
REQ-005 SHALL provide AXI-Lite write response: s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1.
REQ-006 SHALL provide AXI-Lite read: s_axil_araddr in 8, s_axil_arvalid in 1, s_axil_arready out 1, s_axil_rdata out 32, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1.
REQ-007 SHALL provide engine side: start out 1 pulse, algo_sel out 1, i_total_len out 32, key out 128, din out 128, busy in 1, done in 1, dout in 128.

Function
REQ-008 SHALL implement map: 0x00 CTRL RW (bit0 START self-clearing, bit1 ALGO_SEL, bit2 ERR_CLR self-clearing); 0x04 STATUS RO (bit0 busy, bit1 DONE sticky); 0x08 LEN RW; 0x10-0x1C KEY words 3..0 (0x10 = key[127:96]); 0x20-0x2C DIN likewise; 0x30-0x3C DOUT RO likewise; 0x44 ERR_CNT RO.
REQ-009 SHALL latch AW and W independently in either order; awready=1 while no address held and no B pending; wready=1 while no data held and no B pending.
REQ-010 SHALL commit the write on the cycle after both are held, assert bvalid on that commit edge, hold bvalid/bresp until bready, then reopen awready/wready.
REQ-011 SHALL return bresp=2'b00 for RW addresses; 2'b10 (SLVERR) for RO or unmapped addresses, with no state change.
REQ-012 SHALL assert arready=1 in R_IDLE; on arvalid&arready capture address, drive rvalid=1 with registered rdata next cycle, hold until rready, return to R_IDLE.
REQ-013 SHALL return rresp=2'b00 and register value for mapped addresses; rdata=0, rresp=2'b10 for unmapped.
REQ-014 SHALL evaluate CTRL write with START=1: reject if LEN==0, LEN[3:0]!=0, or busy=1; otherwise pulse start high for exactly one cycle, the cycle after commit.
REQ-015 SHALL, on reject, emit no start pulse and increment ERR_CNT by 1, saturating at 0xFFFFFFFF.
REQ-016 SHALL, on CTRL write with ERR_CLR=1, clear ERR_CNT to 0; ERR_CLR wins over a simultaneous reject increment (result 0).
REQ-017 SHALL drive algo_sel, i_total_len, key, din directly from their registers; writes while busy are accepted and visible immediately.
REQ-018 SHALL, on done=1, capture dout into DOUT registers and set STATUS.DONE; an accepted start clears STATUS.DONE on the pulse cycle; done and accepted start same cycle -> DONE set.
REQ-019 SHALL return pre-update value when a DOUT/STATUS/ERR_CNT read is captured on the same edge as its update.
REQ-020 SHALL allow read and write channels to operate concurrently with no mutual stall.

Reset
REQ-021 SHALL, on rst_n=0 at clock edge, clear all registers, ERR_CNT, STATUS.DONE, held AW/W, and return both FSMs to idle.
REQ-022 SHALL hold outputs during reset: start=0, awready=0, wready=0, arready=0, bvalid=0, rvalid=0, rdata=0, bresp=0, rresp=0; ready signals rise the first cycle after rst_n=1.
REQ-023 SHALL abort any in-flight transaction on reset mid-operation with no response issued and no start pulse.

Verification
REQ-024 Write KEY=2b7e1516_28aed2a6_abf71588_09cf4f3c, LEN=64, CTRL=0x1 with busy=0 -> bresp=0, key output matches, one start pulse one cycle after commit, ERR_CNT=0.
REQ-025 LEN=63 then CTRL=0x1 -> no start pulse, read 0x44 returns 1; LEN=17, CTRL=0x1 -> 0x44 returns 2; CTRL=0x4 -> 0x44 returns 0.
REQ-026 LEN=64, busy=1, CTRL=0x1 -> no start, ERR_CNT+1; ERR_CNT preset 0xFFFFFFFF plus reject -> stays 0xFFFFFFFF.
REQ-027 done pulse with dout=7649abac_8119b246_cee98e9b_12e9197d -> read 0x30 returns 0x7649abac, 0x3C returns 0x12e9197d, STATUS=0x2.
REQ-028 W before AW by 3 cycles, bready held low 5 cycles -> single commit, bvalid held stable; write to 0x44 -> SLVERR, ERR_CNT unchanged; read 0x50 -> rdata=0, rresp=2'b10.
REQ-029 Assert rst_n=0 with bvalid pending and rvalid pending -> both drop next edge, all registers 0, no start pulse.
